// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator (OFF/ON/BLINK/BURST) driven by a shared tick prescaler
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_valid/cfg_ready      : config handshake; cfg_chan/cfg_mode/cfg_half/cfg_count carry the request
//   cfg_err                  : 1-cycle pulse when cfg_chan names a nonexistent channel
//   leds                     : LED drive, 1 = lit
//   burst_done               : 1-cycle pulse per channel when its burst finishes
module led_pattern_gen #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int NUM_LEDS = 8,
  parameter int PER_W = 16,
  parameter logic [NUM_LEDS-1:0] RESET_BLINK_MASK = 'h01,
  parameter int RESET_HALF = 500,
  localparam int CW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PER_W-1:0]    cfg_half,
  input  logic [7:0]          cfg_count,
  output logic                cfg_err,
  output logic [NUM_LEDS-1:0] leds,
  output logic [NUM_LEDS-1:0] burst_done
);
  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PER_W-1:0] ONE = PER_W'(1);
  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_e;
  mode_e mode_q [NUM_LEDS];
  mode_e mode_d [NUM_LEDS];
  logic [PER_W-1:0] half_q [NUM_LEDS];
  logic [PER_W-1:0] half_d [NUM_LEDS];
  logic [PER_W-1:0] tcnt_q [NUM_LEDS];
  logic [PER_W-1:0] tcnt_d [NUM_LEDS];
  logic [8:0] rem_q [NUM_LEDS];
  logic [8:0] rem_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_q, led_d, done_q, done_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic cfg_ready_q, cfg_err_q, cfg_err_d, tick, hit;
  always_comb begin
    tick = pcnt_q == PW'(TICK_DIV - 1);
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    hit = cfg_valid & cfg_ready_q;
    cfg_err_d = hit && 32'(cfg_chan) >= NUM_LEDS;
    for (int i = 0; i < NUM_LEDS; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      tcnt_d[i] = tcnt_q[i];
      rem_d[i] = rem_q[i];
      led_d[i] = led_q[i];
      done_d[i] = 1'b0;
      // a config hitting this channel overrides any tick in the same cycle
      if (hit && 32'(cfg_chan) == i) begin
        mode_d[i] = mode_e'(cfg_mode);
        half_d[i] = cfg_half;
        tcnt_d[i] = '0;
        rem_d[i] = {cfg_count, 1'b0} - 9'd1;
        led_d[i] = cfg_mode != 2'd0;
        if (cfg_mode == 2'd3 && cfg_count == 8'd0) begin
          mode_d[i] = M_OFF;
          led_d[i] = 1'b0;
          done_d[i] = 1'b1;
        end
      end else if (tick && (mode_q[i] == M_BLINK || mode_q[i] == M_BURST)) begin
        // half of 0 behaves as 1, so the limit is max(half,1)-1
        if (tcnt_q[i] >= ((half_q[i] == '0) ? '0 : half_q[i] - ONE)) begin
          tcnt_d[i] = '0;
          if (mode_q[i] == M_BURST && rem_q[i] == 9'd0) begin
            mode_d[i] = M_OFF;
            led_d[i] = 1'b0;
            done_d[i] = 1'b1;
          end else begin
            led_d[i] = ~led_q[i];
            rem_d[i] = (mode_q[i] == M_BURST) ? rem_q[i] - 9'd1 : rem_q[i];
          end
        end else tcnt_d[i] = tcnt_q[i] + ONE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q <= 1'b0;
      led_q <= '0;
      done_q <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= RESET_BLINK_MASK[i] ? M_BLINK : M_OFF;
        half_q[i] <= RESET_BLINK_MASK[i] ? PER_W'(RESET_HALF) : '0;
        tcnt_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      pcnt_q <= pcnt_d;
      cfg_ready_q <= 1'b1;
      cfg_err_q <= cfg_err_d;
      led_q <= led_d;
      done_q <= done_d;
      mode_q <= mode_d;
      half_q <= half_d;
      tcnt_q <= tcnt_d;
      rem_q <= rem_d;
    end
  end
  assign cfg_ready = cfg_ready_q;
  assign cfg_err = cfg_err_q;
  assign leds = led_q;
  assign burst_done = done_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: random config traffic on a 4-channel and a 3-channel instance against a tick/event model
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v [2] = '{1'b0, 1'b0};
  logic [1:0] ch [2];
  logic [1:0] md [2];
  logic [15:0] hf [2];
  logic [7:0] ct [2];
  logic rdy_a, rdy_b, err_a, err_b;
  logic [3:0] leds_a, done_a;
  logic [2:0] leds_b, done_b;
  int checks = 0;
  int errors = 0;
  int cyc;
  int m_mode [2][4];
  int m_half [2][4];
  int m_phase [2][4];
  int m_left [2][4];
  bit m_led [2][4];
  bit m_done [2][4];
  bit m_err [2];
  bit m_rdy [2];
  always #5 clk = ~clk;
  led_pattern_gen #(.CLK_FREQ(1000), .TICK_HZ(100), .NUM_LEDS(4), .PER_W(16),
    .RESET_BLINK_MASK(4'h1), .RESET_HALF(5)) dut_a (
    .clk(clk), .rst(rst), .cfg_valid(v[0]), .cfg_ready(rdy_a), .cfg_chan(ch[0]),
    .cfg_mode(md[0]), .cfg_half(hf[0]), .cfg_count(ct[0]), .cfg_err(err_a),
    .leds(leds_a), .burst_done(done_a));
  led_pattern_gen #(.CLK_FREQ(1000), .TICK_HZ(100), .NUM_LEDS(3), .PER_W(16),
    .RESET_BLINK_MASK(3'h1), .RESET_HALF(5)) dut_b (
    .clk(clk), .rst(rst), .cfg_valid(v[1]), .cfg_ready(rdy_b), .cfg_chan(ch[1]),
    .cfg_mode(md[1]), .cfg_half(hf[1]), .cfg_count(ct[1]), .cfg_err(err_b),
    .leds(leds_b), .burst_done(done_b));
  task automatic check(string tag, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, k, got, exp);
    end
  endtask
  // advance the model across the coming clock edge using the inputs now applied
  task automatic step();
    bit tk;
    if (rst) begin
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
        m_err[d] = 0;
        m_rdy[d] = 0;
        for (int c = 0; c < 4; c++) begin
          m_mode[d][c] = (c == 0) ? 2 : 0;
          m_half[d][c] = 5;
          m_phase[d][c] = 0;
          m_left[d][c] = 0;
          m_led[d][c] = 0;
          m_done[d][c] = 0;
        end
      end
    end else begin
      tk = (cyc % 10) == 9;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        int n;
        bit acc;
        n = (d == 0) ? 4 : 3;
        acc = v[d] && m_rdy[d];
        m_err[d] = acc && (int'(ch[d]) >= n);
        m_rdy[d] = 1;
        for (int c = 0; c < n; c++) begin
          m_done[d][c] = 0;
          if (acc && int'(ch[d]) == c) begin
            m_mode[d][c] = int'(md[d]);
            m_half[d][c] = (hf[d] == 0) ? 1 : int'(hf[d]);
            m_phase[d][c] = 0;
            m_led[d][c] = md[d] != 0;
            m_left[d][c] = 2 * int'(ct[d]);
            if (md[d] == 3 && ct[d] == 0) begin
              m_mode[d][c] = 0;
              m_led[d][c] = 0;
              m_done[d][c] = 1;
            end
          end else if (tk && m_mode[d][c] >= 2) begin
            m_phase[d][c]++;
            if (m_phase[d][c] >= m_half[d][c]) begin
              m_phase[d][c] = 0;
              if (m_mode[d][c] == 3) begin
                m_left[d][c]--;
                if (m_left[d][c] == 0) begin
                  m_mode[d][c] = 0;
                  m_led[d][c] = 0;
                  m_done[d][c] = 1;
                end else m_led[d][c] = !m_led[d][c];
              end else m_led[d][c] = !m_led[d][c];
            end
          end
        end
      end
    end
  endtask
  task automatic compare(int k);
    logic [3:0] el, ed;
    for (int d = 0; d < 2; d++) begin
      el = '0;
      ed = '0;
      for (int c = 0; c < 4; c++) begin
        el[c] = m_led[d][c];
        ed[c] = m_done[d][c];
      end
      if (d == 0) begin
        check("leds_a", k, 32'(leds_a), 32'(el));
        check("done_a", k, 32'(done_a), 32'(ed));
        check("err_a", k, 32'(err_a), 32'(m_err[0]));
        check("ready_a", k, 32'(rdy_a), 32'(m_rdy[0]));
      end else begin
        check("leds_b", k, 32'(leds_b), 32'(el[2:0]));
        check("done_b", k, 32'(done_b), 32'(ed[2:0]));
        check("err_b", k, 32'(err_b), 32'(m_err[1]));
        check("ready_b", k, 32'(rdy_b), 32'(m_rdy[1]));
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (k > 0) compare(k);
      rst = (k < 3) || (k > 300 && $urandom_range(0, 599) == 0);
      for (int d = 0; d < 2; d++) begin
        v[d] = (k >= 260) && ($urandom_range(0, 7) == 0);
        ch[d] = 2'($urandom_range(0, 3));
        md[d] = 2'($urandom_range(0, 3));
        hf[d] = 16'($urandom_range(0, 3));
        ct[d] = 8'($urandom_range(0, 3));
      end
      if (k == 150) begin
        v[0] = 1; ch[0] = 2; md[0] = 3; hf[0] = 2; ct[0] = 3;
      end
      if (k == 200 || k == 202) begin
        v[0] = 1; ch[0] = 1; md[0] = (k == 200) ? 2'd1 : 2'd0;
      end
      if (k == 210) begin
        v[1] = 1; ch[1] = 3; md[1] = 1;
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
